// File: rtl/simd_decoder.sv
// P-extension add/sub/cross/straight decode stage.
// Classifies OP-P words into SIMD op codes with one registered cycle.
module simd_decoder #(
    parameter int OP_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic            is_compressed_i,
    input  logic [31:0]     instr_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic            simd_o,
    output logic            illegal_o,
    output logic [OP_W-1:0] op_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o
);

    localparam logic [6:0] OPC_P = 7'b1110111;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [5:0]      w_code;
    logic            w_valid;
    logic            w_is_p;
    logic            w_simd;
    logic            w_illegal;

    logic            r_valid;
    logic            r_simd;
    logic            r_illegal;
    logic [OP_W-1:0] r_op;
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];

    always_comb begin
        w_code = 6'd0;
        if (w_funct3 == 3'b000) begin
            case (w_funct7)
                7'b0100000: w_code = 6'd1;
                7'b0100001: w_code = 6'd2;
                7'b0100100: w_code = 6'd3;
                7'b0100101: w_code = 6'd4;
                7'b0000000: w_code = 6'd5;
                7'b0000001: w_code = 6'd6;
                7'b0000100: w_code = 6'd7;
                7'b0000101: w_code = 6'd8;
                7'b0010000: w_code = 6'd9;
                7'b0010001: w_code = 6'd10;
                7'b0010100: w_code = 6'd11;
                7'b0010101: w_code = 6'd12;
                7'b0001000: w_code = 6'd13;
                7'b0001001: w_code = 6'd14;
                7'b0001100: w_code = 6'd15;
                7'b0001101: w_code = 6'd16;
                7'b0011000: w_code = 6'd17;
                7'b0011001: w_code = 6'd18;
                7'b0011100: w_code = 6'd19;
                7'b0011101: w_code = 6'd20;
                7'b0100010: w_code = 6'd21;
                7'b0100011: w_code = 6'd22;
                7'b0000010: w_code = 6'd23;
                7'b0000011: w_code = 6'd24;
                7'b0010010: w_code = 6'd25;
                7'b0010011: w_code = 6'd26;
                7'b0001010: w_code = 6'd27;
                7'b0001011: w_code = 6'd28;
                7'b0011010: w_code = 6'd29;
                7'b0011011: w_code = 6'd30;
                default:    w_code = 6'd0;
            endcase
        end else if (w_funct3 == 3'b010) begin
            case (w_funct7)
                7'b1111010: w_code = 6'd31;
                7'b1111011: w_code = 6'd32;
                7'b1011010: w_code = 6'd33;
                7'b1011011: w_code = 6'd34;
                7'b1101010: w_code = 6'd35;
                7'b1101011: w_code = 6'd36;
                7'b1100010: w_code = 6'd37;
                7'b1100011: w_code = 6'd38;
                7'b1110010: w_code = 6'd39;
                7'b1110011: w_code = 6'd40;
                default:    w_code = 6'd0;
            endcase
        end
    end

    // Compressed expansions never map onto OP-P, so they are not flagged.
    assign w_valid   = valid_i & ~flush_i;
    assign w_is_p    = w_valid & (w_opcode == OPC_P) & ~is_compressed_i;
    assign w_simd    = w_is_p & (w_code != 6'd0);
    assign w_illegal = w_is_p & (w_code == 6'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_simd    <= 1'b0;
            r_illegal <= 1'b0;
            r_op      <= '0;
            r_rd      <= 5'd0;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
        end else begin
            r_valid   <= w_valid;
            r_simd    <= w_simd;
            r_illegal <= w_illegal;
            r_op      <= w_simd ? OP_W'(w_code) : '0;
            r_rd      <= instr_i[11:7];
            r_rs1     <= instr_i[19:15];
            r_rs2     <= instr_i[24:20];
        end
    end

    assign valid_o   = r_valid;
    assign simd_o    = r_simd;
    assign illegal_o = r_illegal;
    assign op_o      = r_op;
    assign rd_o      = r_rd;
    assign rs1_o     = r_rs1;
    assign rs2_o     = r_rs2;

endmodule

// File: tb/tb_simd_decoder.sv
// Bench for simd_decoder: table-lookup reference model plus
// per-cycle compare and pinned literal checks.
`timescale 1ns/1ps
module tb_simd_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        comp = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr = 32'd0;

    logic        d_valid;
    logic        d_simd;
    logic        d_ill;
    logic [5:0]  d_op;
    logic [4:0]  d_rd;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;

    int n_checks = 0;
    int n_errs = 0;

    simd_decoder #(.OP_W(6)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .valid_i(valid),
        .is_compressed_i(comp),
        .instr_i(instr),
        .flush_i(flush),
        .valid_o(d_valid),
        .simd_o(d_simd),
        .illegal_o(d_ill),
        .op_o(d_op),
        .rd_o(d_rd),
        .rs1_o(d_rs1),
        .rs2_o(d_rs2)
    );

    always #10 clk = ~clk;

    // Entry k holds {funct3, funct7} of op code k+1.
    localparam logic [9:0] TBL [40] = '{
        10'b000_0100000, 10'b000_0100001, 10'b000_0100100, 10'b000_0100101,
        10'b000_0000000, 10'b000_0000001, 10'b000_0000100, 10'b000_0000101,
        10'b000_0010000, 10'b000_0010001, 10'b000_0010100, 10'b000_0010101,
        10'b000_0001000, 10'b000_0001001, 10'b000_0001100, 10'b000_0001101,
        10'b000_0011000, 10'b000_0011001, 10'b000_0011100, 10'b000_0011101,
        10'b000_0100010, 10'b000_0100011, 10'b000_0000010, 10'b000_0000011,
        10'b000_0010010, 10'b000_0010011, 10'b000_0001010, 10'b000_0001011,
        10'b000_0011010, 10'b000_0011011,
        10'b010_1111010, 10'b010_1111011, 10'b010_1011010, 10'b010_1011011,
        10'b010_1101010, 10'b010_1101011, 10'b010_1100010, 10'b010_1100011,
        10'b010_1110010, 10'b010_1110011
    };

    function automatic int lookup(input logic [31:0] w);
        logic [9:0] key;
        key = {w[14:12], w[31:25]};
        for (int k = 0; k < 40; k++)
            if (TBL[k] == key) return k + 1;
        return 0;
    endfunction

    function automatic logic [31:0] mk(input logic [9:0] f,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {f[6:0], rs2, rs1, f[9:7], rd, 7'b1110111};
    endfunction

    logic       e_valid = 1'b0;
    logic       e_simd = 1'b0;
    logic       e_ill = 1'b0;
    logic [5:0] e_op = 6'd0;
    logic [4:0] e_rd = 5'd0;
    logic [4:0] e_rs1 = 5'd0;
    logic [4:0] e_rs2 = 5'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= 1'b0; e_simd <= 1'b0; e_ill <= 1'b0;
            e_op <= 6'd0; e_rd <= 5'd0; e_rs1 <= 5'd0; e_rs2 <= 5'd0;
        end else begin
            int  c;
            bit  v;
            bit  p;
            v = valid && !flush;
            p = v && instr[6:0] == 7'h77 && !comp;
            c = p ? lookup(instr) : 0;
            e_valid <= v;
            e_simd  <= c != 0;
            e_ill   <= p && c == 0;
            e_op    <= 6'(c);
            e_rd    <= instr[11:7];
            e_rs1   <= instr[19:15];
            e_rs2   <= instr[24:20];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        n_checks++;
        if ({d_valid, d_simd, d_ill, d_op, d_rd, d_rs1, d_rs2} !==
            {e_valid, e_simd, e_ill, e_op, e_rd, e_rs1, e_rs2}) begin
            n_errs++;
            $display("FAIL cycle: got v%0b s%0b i%0b op%0d rd%0d rs1%0d rs2%0d expected v%0b s%0b i%0b op%0d rd%0d rs1%0d rs2%0d at %0t",
                     d_valid, d_simd, d_ill, d_op, d_rd, d_rs1, d_rs2,
                     e_valid, e_simd, e_ill, e_op, e_rd, e_rs1, e_rs2, $time);
        end
    end

    task automatic drive(input bit v, input bit c, input bit f,
                         input logic [31:0] w);
        @(posedge clk);
        #1;
        valid = v; comp = c; flush = f; instr = w;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        valid = 1'b1;
        instr = 32'h401101F7;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", d_valid, 0);
        check("rst_op", d_op, 0);
        check("rst_fields", {d_rd, d_rs1, d_rs2}, 0);
        rst_n = 1'b1;
        after_edge();
        check("add16_valid", d_valid, 1);
        check("add16_simd", d_simd, 1);
        check("add16_op", d_op, 1);
        check("add16_rd", d_rd, 3);
        check("add16_rs1", d_rs1, 2);
        check("add16_rs2", d_rs2, 1);

        for (int k = 0; k < 40; k++) begin
            drive(1, 0, 0, mk(TBL[k], 5'd3, 5'd2, 5'd1));
            after_edge();
            check($sformatf("sweep_op%0d", k + 1), d_op, k + 1);
        end

        drive(1, 0, 0, 32'h421101F7); after_edge();
        check("sub16", d_op, 2);
        drive(1, 0, 0, 32'h181101F7); after_edge();
        check("kadd8", d_op, 15);
        drive(1, 0, 0, 32'h3A1101F7); after_edge();
        check("uksub8", d_op, 20);
        drive(1, 0, 0, 32'hF45121F7); after_edge();
        check("stas16", d_op, 31);
        check("stas16_rs2", d_rs2, 5);
        drive(1, 0, 0, 32'hF45101F7); after_edge();
        check("stas16_f3_ill", d_ill, 1);
        check("stas16_f3_op", d_op, 0);
        drive(1, 0, 0, 32'h002081B3); after_edge();
        check("add_valid", d_valid, 1);
        check("add_simd", d_simd, 0);
        check("add_ill", d_ill, 0);
        drive(1, 1, 0, 32'h401101F7); after_edge();
        check("comp_op", d_op, 0);
        check("comp_ill", d_ill, 0);
        drive(1, 0, 0, 32'hFE1101F7); after_edge();
        check("f7_ones_ill", d_ill, 1);
        drive(0, 0, 0, 32'h401101F7); after_edge();
        check("novalid_v", d_valid, 0);
        check("novalid_op", d_op, 0);
        drive(1, 0, 1, 32'h481101F7); after_edge();
        check("flush_v", d_valid, 0);
        check("flush_op", d_op, 0);

        drive(1, 0, 0, 32'h481101F7); after_edge();
        check("add8", d_op, 3);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_v", d_valid, 0);
        check("async_op", d_op, 0);
        check("async_rd", d_rd, 0);
        #2;
        rst_n = 1'b1;
        after_edge();
        check("post_async", d_op, 3);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            int sel;
            sel = $urandom_range(0, 9);
            w = $urandom;
            if (sel < 5)
                w = mk(TBL[$urandom_range(0, 39)], w[11:7], w[19:15], w[24:20]);
            else if (sel < 8)
                w[6:0] = 7'h77;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, w);
        end
        drive(0, 0, 0, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/simd_decoder.md
Name: simd_decoder

Overview:
- Pipelined decode stage for the RISC-V P-extension (packed SIMD) add/subtract/cross/straight instruction group, major opcode OP-P (7'b1110111).
- Takes one 32-bit uncompressed instruction per cycle and classifies it into one of 40 SIMD operation codes plus register indices, registered with 1-cycle latency.
- Sits beside the main instruction decoder; its op code drives the SIMD ALU issue path.

Parameters:
- OP_W, 6, width of op_o; must be at least 6.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  instr_i is valid this cycle
- is_compressed_i  in  1  instruction came from an RVC expansion
- instr_i  in  32  raw instruction word
- flush_i  in  1  kill the in-flight decode
- valid_o  out  1  registered outputs are valid
- simd_o  out  1  instruction is a recognised SIMD op
- illegal_o  out  1  OP-P opcode but unsupported funct7/funct3 combination
- op_o  out  OP_W  operation code, 0 = none
- rd_o  out  5  instr[11:7]
- rs1_o  out  5  instr[19:15]
- rs2_o  out  5  instr[24:20]

Behaviour:
- Fields:
  - opcode = instr[6:0]
  - funct3 = instr[14:12]
  - funct7 = instr[31:25]
- Decoding is combinational. All outputs are registered on the rising clk_i edge, so latency is exactly 1 cycle and throughput is 1 per cycle. There is no backpressure.
- Reset (async, rst_ni=0): every output is 0 immediately. Outputs stay 0 until the first clock edge after deassertion.
- Each cycle:
  - valid_o <= valid_i & ~flush_i.
  - If that value is 0, then simd_o, illegal_o and op_o are 0. rd_o, rs1_o and rs2_o still load their fields.
- SIMD match conditions: opcode == 1110111 and is_compressed_i == 0, with the funct3/funct7 pairs below.
- funct3 = 000 group, as op code: funct7:
  - 1 ADD16: 0100000
  - 2 SUB16: 0100001
  - 3 ADD8: 0100100
  - 4 SUB8: 0100101
  - 5 RADD16: 0000000
  - 6 RSUB16: 0000001
  - 7 RADD8: 0000100
  - 8 RSUB8: 0000101
  - 9 URADD16: 0010000
  - 10 URSUB16: 0010001
  - 11 URADD8: 0010100
  - 12 URSUB8: 0010101
  - 13 KADD16: 0001000
  - 14 KSUB16: 0001001
  - 15 KADD8: 0001100
  - 16 KSUB8: 0001101
  - 17 UKADD16: 0011000
  - 18 UKSUB16: 0011001
  - 19 UKADD8: 0011100
  - 20 UKSUB8: 0011101
  - 21 CRAS16: 0100010
  - 22 CRSA16: 0100011
  - 23 RCRAS16: 0000010
  - 24 RCRSA16: 0000011
  - 25 URCRAS16: 0010010
  - 26 URCRSA16: 0010011
  - 27 KCRAS16: 0001010
  - 28 KCRSA16: 0001011
  - 29 UKCRAS16: 0011010
  - 30 UKCRSA16: 0011011
- funct3 = 010 group, as op code: funct7:
  - 31 STAS16: 1111010
  - 32 STSA16: 1111011
  - 33 RSTAS16: 1011010
  - 34 RSTSA16: 1011011
  - 35 URSTAS16: 1101010
  - 36 URSTSA16: 1101011
  - 37 KSTAS16: 1100010
  - 38 KSTSA16: 1100011
  - 39 UKSTAS16: 1110010
  - 40 UKSTSA16: 1110011
- Match: simd_o=1, illegal_o=0, op_o=code.
- opcode == 1110111 (and not compressed) but no entry matches, including a valid funct7 paired with the wrong funct3: simd_o=0, illegal_o=1, op_o=0.
- Any other opcode, or is_compressed_i=1: simd_o=0, illegal_o=0, op_o=0. valid_o still follows valid_i.
- Field extraction is independent of match result.
- Simultaneous flush_i and valid_i: flush wins, valid_o=0.
- Reset asserted mid-stream: outputs clear asynchronously and the in-flight instruction is discarded.

Test Plan:
- Reset: hold rst_ni=0 with valid_i=1 and instr 0x401101F7 -> all outputs 0. Release, next edge -> valid_o=1, simd_o=1, op_o=1 (ADD16), rd_o=3, rs1_o=2, rs2_o=1.
- Back-to-back sweep of all 40 encodings with rd=3, rs1=2, rs2=1 (e.g. SUB16 0x421101F7 -> 2, KADD8 0x181101F7 -> 15, UKSUB8 0x3A1101F7 -> 20) -> each op code appears exactly one cycle after its input.
- STAS16 x3,x2,x5 = 0xF45121F7 -> op_o=31. The same word with funct3=000 (0xF45101F7) -> illegal_o=1, op_o=0.
- Non-SIMD: add x3,x1,x2 (0x002081B3) -> valid_o=1, simd_o=0, illegal_o=0, op_o=0. Instr 0x401101F7 with is_compressed_i=1 -> op_o=0, illegal_o=0.
- Illegal funct7 1111111 on OP-P with funct3=000 -> illegal_o=1. valid_i=0 with a legal word -> valid_o=0, op_o=0.
- flush_i=1 together with valid_i=1 on ADD8 (0x481101F7) -> next cycle valid_o=0, op_o=0. Async reset pulse between edges -> outputs drop immediately.
